// File: rtl/rv_pkg.sv
// Shared encodings for the multicycle RV32I control path and the rv_dp datapath:
// FSM states, opcodes and every select/ALU code.
package rv_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_ALU_WB   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WB   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_JUMP     = 4'd12,
        S_ILLEGAL  = 4'd13
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic PC_PLUS4 = 1'b0;
    localparam logic PC_ALU   = 1'b1;

    localparam logic [1:0] WB_MDR    = 2'd0;
    localparam logic [1:0] WB_ALUOUT = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;

    localparam logic [1:0] IMM_J = 2'd0;
    localparam logic [1:0] IMM_B = 2'd1;
    localparam logic [1:0] IMM_S = 2'd2;
    localparam logic [1:0] IMM_L = 2'd3;

    localparam logic [1:0] ALUA_REG    = 2'd0;
    localparam logic [1:0] ALUA_PCC    = 2'd1;
    localparam logic [1:0] ALUA_ALUOUT = 2'd2;

    localparam logic [1:0] ALUB_REG   = 2'd0;
    localparam logic [1:0] ALUB_IMM   = 2'd1;
    localparam logic [1:0] ALUB_CONST = 2'd2;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

endpackage

// File: rtl/rv_alu_dec.sv
// ALU operation decode from funct3/funct7[5]; SUB only exists for R-type,
// for immediates funct7[5] only distinguishes SRL from SRA.
module rv_alu_dec
    import rv_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       is_rtype,
    output logic [3:0] alusel
);

    // funct3 to ALU operation
    always_comb begin
        alusel = ALU_ADD;
        case (funct3)
            3'b000:  alusel = (is_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  alusel = ALU_SLL;
            3'b010:  alusel = ALU_SLT;
            3'b011:  alusel = ALU_SLTU;
            3'b100:  alusel = ALU_XOR;
            3'b101:  alusel = funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  alusel = ALU_OR;
            3'b111:  alusel = ALU_AND;
            default: alusel = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/rv_ctl.sv
// Multicycle control FSM for rv_dp: one state per cycle, outputs decoded from
// state, instr and zero; unsupported encodings park the machine in ILLEGAL.
module rv_ctl
    import rv_pkg::*;
#(
    parameter int DPWIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DPWIDTH-1:0] instr,
    input  logic               zero,
    output logic               pcsourse,
    output logic               pcwrite,
    output logic               pccen,
    output logic               irwrite,
    output logic               regwen,
    output logic               mdrwrite,
    output logic               dmem_wen,
    output logic [1:0]         wbsel,
    output logic [1:0]         immsel,
    output logic [1:0]         asel,
    output logic [1:0]         bsel,
    output logic [3:0]         alusel,
    output logic               retire,
    output logic               illegal
);

    state_e     state_q, state_d;
    logic       illegal_q, illegal_d;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic [3:0] alu_dec_op;
    logic       unused_instr;

    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign funct7_5     = instr[30];
    assign unused_instr = ^{instr[DPWIDTH-1:31], instr[29:15], instr[11:7]};
    assign illegal      = illegal_q;

    rv_alu_dec u_alu_dec (
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .is_rtype (opcode == OP_R),
        .alusel   (alu_dec_op)
    );

    // State and sticky illegal flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Next state and datapath controls; everything stays low while in reset
    always_comb begin
        state_d  = state_q;
        pcsourse = PC_PLUS4;
        pcwrite  = 1'b0;
        pccen    = 1'b0;
        irwrite  = 1'b0;
        regwen   = 1'b0;
        mdrwrite = 1'b0;
        dmem_wen = 1'b0;
        wbsel    = WB_MDR;
        immsel   = IMM_J;
        asel     = ALUA_REG;
        bsel     = ALUB_REG;
        alusel   = ALU_ADD;
        retire   = 1'b0;
        if (rst) begin
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: begin
                    irwrite = 1'b1;
                    pccen   = 1'b1;
                    pcwrite = 1'b1;
                    state_d = S_DECODE;
                end
                S_DECODE: begin
                    // branch target is computed here speculatively and held in aluout
                    asel   = ALUA_PCC;
                    bsel   = ALUB_IMM;
                    immsel = IMM_B;
                    case (opcode)
                        OP_R:      state_d = S_EXEC_R;
                        OP_I:      state_d = (funct3 == 3'b101 && funct7_5) ? S_ILLEGAL : S_EXEC_I;
                        OP_LOAD:   state_d = (funct3 == 3'b010) ? S_MEM_ADDR : S_ILLEGAL;
                        OP_STORE:  state_d = (funct3 == 3'b010) ? S_MEM_ADDR : S_ILLEGAL;
                        OP_BRANCH: state_d = (funct3[2:1] == 2'b00) ? S_BRANCH : S_ILLEGAL;
                        OP_JAL:    state_d = S_JAL;
                        OP_JALR:   state_d = (funct3 == 3'b000) ? S_JALR : S_ILLEGAL;
                        default:   state_d = S_ILLEGAL;
                    endcase
                end
                S_EXEC_R: begin
                    alusel  = alu_dec_op;
                    state_d = S_ALU_WB;
                end
                S_EXEC_I: begin
                    bsel    = ALUB_IMM;
                    immsel  = IMM_L;
                    alusel  = alu_dec_op;
                    state_d = S_ALU_WB;
                end
                S_ALU_WB: begin
                    wbsel   = WB_ALUOUT;
                    regwen  = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
                S_MEM_ADDR: begin
                    bsel    = ALUB_IMM;
                    immsel  = (opcode == OP_STORE) ? IMM_S : IMM_L;
                    state_d = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
                end
                S_MEM_RD: begin
                    mdrwrite = 1'b1;
                    state_d  = S_MEM_WB;
                end
                S_MEM_WB: begin
                    wbsel   = WB_MDR;
                    regwen  = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
                S_MEM_WR: begin
                    dmem_wen = 1'b1;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end
                S_BRANCH: begin
                    alusel = ALU_SUB;
                    retire = 1'b1;
                    if ((funct3 == 3'b000 && zero) || (funct3 == 3'b001 && !zero)) begin
                        pcwrite  = 1'b1;
                        pcsourse = PC_ALU;
                    end else begin
                        pcwrite  = 1'b0;
                        pcsourse = PC_PLUS4;
                    end
                    state_d = S_FETCH;
                end
                S_JAL: begin
                    asel    = ALUA_PCC;
                    bsel    = ALUB_IMM;
                    immsel  = IMM_J;
                    wbsel   = WB_PC;
                    regwen  = 1'b1;
                    state_d = S_JUMP;
                end
                S_JALR: begin
                    bsel    = ALUB_IMM;
                    immsel  = IMM_L;
                    wbsel   = WB_PC;
                    regwen  = 1'b1;
                    state_d = S_JUMP;
                end
                S_JUMP: begin
                    pcwrite  = 1'b1;
                    pcsourse = PC_ALU;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end
                S_ILLEGAL: begin
                    state_d = S_ILLEGAL;
                end
                default: begin
                    state_d = S_ILLEGAL;
                end
            endcase
        end
        illegal_d = illegal_q | (state_d == S_ILLEGAL);
    end

endmodule

// File: tb/tb_rv_ctl.sv
// Scoreboard bench for rv_ctl: each scenario queues the expected per-cycle
// control vector, then pops and compares one entry per clock.
module tb_rv_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        zero;
    logic        pcsourse, pcwrite, pccen, irwrite, regwen, mdrwrite, dmem_wen;
    logic [1:0]  wbsel, immsel, asel, bsel;
    logic [3:0]  alusel;
    logic        retire, illegal;

    int checks = 0;
    int errors = 0;
    logic [20:0] sb[$];
    logic [20:0] exp_v;
    wire  [20:0] obs = {pcsourse, pcwrite, pccen, irwrite, regwen, mdrwrite, dmem_wen,
                        wbsel, immsel, asel, bsel, alusel, retire, illegal};

    rv_ctl #(.DPWIDTH(32)) dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero),
        .pcsourse(pcsourse), .pcwrite(pcwrite), .pccen(pccen), .irwrite(irwrite),
        .regwen(regwen), .mdrwrite(mdrwrite), .dmem_wen(dmem_wen),
        .wbsel(wbsel), .immsel(immsel), .asel(asel), .bsel(bsel),
        .alusel(alusel), .retire(retire), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Field order: pcs pcw pcc irw rw mdr dw wb imm a b alu ret ill
    function automatic logic [20:0] ev(input logic pcs, pcw, pcc, irw, rw, mdr, dw,
                                       input logic [1:0] wb, imm, a, b,
                                       input logic [3:0] alu, input logic ret, ill);
        return {pcs, pcw, pcc, irw, rw, mdr, dw, wb, imm, a, b, alu, ret, ill};
    endfunction

    task automatic push_fetch_decode();
        sb.push_back(ev(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0));
        sb.push_back(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd1, 2'd1, 4'd0, 1'b0, 1'b0));
    endtask

    task automatic test_reset();
        rst = 1'b1; instr = 32'h0000_0013; zero = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (obs !== 21'd0) begin
            errors++; $display("FAIL reset_hold got %h exp %h", obs, 21'd0);
        end
        @(posedge clk); #1 rst = 1'b0;
        sb.push_back(ev(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0));
        @(negedge clk);
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL reset_first_fetch got %h exp %h", obs, exp_v);
        end
        // DUT now in DECODE with a NOP-like addi; finish it so the machine is in sync
        sb.push_back(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd1, 2'd1, 4'd0, 1'b0, 1'b0));
        sb.push_back(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3, 2'd0, 2'd1, 4'd0, 1'b0, 1'b0));
        sb.push_back(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0, 2'd0, 4'd0, 1'b1, 1'b0));
        for (int k = 0; sb.size() > 0; k++) begin
            @(negedge clk); exp_v = sb.pop_front(); checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL reset_addi cyc%0d got %h exp %h", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_r_type();
        logic [31:0] ops [4] = '{32'h0020_81B3, 32'h4020_81B3, 32'h4020_D1B3, 32'h0020_F1B3};
        logic [3:0]  alu [4] = '{4'd0, 4'd1, 4'd7, 4'd9};
        for (int i = 0; i < 4; i++) begin
            instr = ops[i];
            push_fetch_decode();
            sb.push_back(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, alu[i], 1'b0, 1'b0));
            sb.push_back(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0, 2'd0, 4'd0, 1'b1, 1'b0));
            for (int k = 0; sb.size() > 0; k++) begin
                @(negedge clk); exp_v = sb.pop_front(); checks++;
                if (obs !== exp_v) begin
                    errors++; $display("FAIL r_type%0d cyc%0d got %h exp %h", i, k, obs, exp_v);
                end
            end
        end
    endtask

    task automatic test_i_type();
        logic [31:0] ops [2] = '{32'h0051_4093, 32'h0010_D093};
        logic [3:0]  alu [2] = '{4'd5, 4'd6};
        for (int i = 0; i < 2; i++) begin
            instr = ops[i];
            push_fetch_decode();
            sb.push_back(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3, 2'd0, 2'd1, alu[i], 1'b0, 1'b0));
            sb.push_back(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0, 2'd0, 4'd0, 1'b1, 1'b0));
            for (int k = 0; sb.size() > 0; k++) begin
                @(negedge clk); exp_v = sb.pop_front(); checks++;
                if (obs !== exp_v) begin
                    errors++; $display("FAIL i_type%0d cyc%0d got %h exp %h", i, k, obs, exp_v);
                end
            end
        end
    endtask

    task automatic test_load_store();
        instr = 32'h0080_A283;
        push_fetch_decode();
        sb.push_back(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3, 2'd0, 2'd1, 4'd0, 1'b0, 1'b0));
        sb.push_back(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0));
        sb.push_back(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0, 1'b1, 1'b0));
        for (int k = 0; sb.size() > 0; k++) begin
            @(negedge clk); exp_v = sb.pop_front(); checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL lw cyc%0d got %h exp %h", k, obs, exp_v);
            end
        end
        instr = 32'h0050_A423;
        push_fetch_decode();
        sb.push_back(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, 2'd1, 4'd0, 1'b0, 1'b0));
        sb.push_back(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0, 1'b1, 1'b0));
        for (int k = 0; sb.size() > 0; k++) begin
            @(negedge clk); exp_v = sb.pop_front(); checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL sw cyc%0d got %h exp %h", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_branch();
        logic [31:0] ops [4] = '{32'h0020_8463, 32'h0020_8463, 32'h0020_9463, 32'h0020_9463};
        logic        zin [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic        tkn [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            instr = ops[i]; zero = zin[i];
            push_fetch_decode();
            sb.push_back(ev(tkn[i], tkn[i], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 4'd1, 1'b1, 1'b0));
            for (int k = 0; sb.size() > 0; k++) begin
                @(negedge clk); exp_v = sb.pop_front(); checks++;
                if (obs !== exp_v) begin
                    errors++; $display("FAIL branch%0d cyc%0d got %h exp %h", i, k, obs, exp_v);
                end
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_jump();
        logic [31:0] ops [2] = '{32'h0100_00EF, 32'h0000_80E7};
        logic [1:0]  av  [2] = '{2'd1, 2'd0};
        logic [1:0]  iv  [2] = '{2'd0, 2'd3};
        for (int i = 0; i < 2; i++) begin
            instr = ops[i];
            push_fetch_decode();
            sb.push_back(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, iv[i], av[i], 2'd1, 4'd0, 1'b0, 1'b0));
            sb.push_back(ev(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0, 1'b1, 1'b0));
            for (int k = 0; sb.size() > 0; k++) begin
                @(negedge clk); exp_v = sb.pop_front(); checks++;
                if (obs !== exp_v) begin
                    errors++; $display("FAIL jump%0d cyc%0d got %h exp %h", i, k, obs, exp_v);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        instr = 32'h0020_81B3;
        push_fetch_decode();
        for (int k = 0; sb.size() > 0; k++) begin
            @(negedge clk); exp_v = sb.pop_front(); checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL midrst_pre cyc%0d got %h exp %h", k, obs, exp_v);
            end
        end
        rst = 1'b1; #1;
        checks++;
        if (obs !== 21'd0) begin
            errors++; $display("FAIL midrst_async got %h exp %h", obs, 21'd0);
        end
        @(posedge clk); #1;
        checks++;
        if (obs !== 21'd0) begin
            errors++; $display("FAIL midrst_hold got %h exp %h", obs, 21'd0);
        end
        rst = 1'b0;
        // abandoned add restarts from FETCH
        push_fetch_decode();
        sb.push_back(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0));
        sb.push_back(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0, 2'd0, 4'd0, 1'b1, 1'b0));
        for (int k = 0; sb.size() > 0; k++) begin
            @(negedge clk); exp_v = sb.pop_front(); checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL midrst_post cyc%0d got %h exp %h", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] ops [2] = '{32'h0000_12B7, 32'h4010_D093};
        for (int i = 0; i < 2; i++) begin
            instr = ops[i];
            push_fetch_decode();
            repeat (20) sb.push_back(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                        2'd0, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b1));
            for (int k = 0; sb.size() > 0; k++) begin
                @(negedge clk); exp_v = sb.pop_front(); checks++;
                if (obs !== exp_v) begin
                    errors++; $display("FAIL illegal%0d cyc%0d got %h exp %h", i, k, obs, exp_v);
                end
            end
            rst = 1'b1; #1;
            checks++;
            if (obs !== 21'd0) begin
                errors++; $display("FAIL illegal%0d_clear got %h exp %h", i, obs, 21'd0);
            end
            @(posedge clk); #1 rst = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_i_type();
        test_load_store();
        test_branch();
        test_jump();
        test_mid_reset();
        test_illegal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
